cgra_stream_if: RTL and testbench
=================================

CGRA_STREAM_IF -- requirements
Module: cgra_stream_if

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of load/store channel pairs (1..8).
REQ-002 SHALL have parameter DWIDTH, default 32: data width per channel.
REQ-003 SHALL have parameter AWIDTH, default 10: word-address and cycle-count width.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 8: post-run cycles during which stores are still accepted (1..255).
REQ-005 SHALL have parameter BYTE_LEN, default DWIDTH/8: byte-enable width per channel.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- Clk  in  1  sole clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Computation_Start  in  1  software start level.
- Cycle_Count  in  AWIDTH  number of load cycles; sampled at start.
- Computation_Done  out  1  completion flag.
- PE_Array_Busy  out  1  PE array running.
- Ld_En  out  CHANNELS  load-port enable per channel.
- Ld_Addr  out  CHANNELS*AWIDTH  load word address; channel c occupies bits [c*AWIDTH +: AWIDTH].
- Ld_Rdata  in  CHANNELS*DWIDTH  BRAM read data, 1-cycle latency.
- Data_To_CGRA  out  CHANNELS*DWIDTH  registered load data to the PE array.
- Data_From_CGRA  in  CHANNELS*DWIDTH  PE array store data.
- Store_Valid  in  CHANNELS  per-channel store request.
- St_En  out  CHANNELS  store-port enable.
- St_Wen  out  CHANNELS*BYTE_LEN  byte write enables.
- St_Addr  out  CHANNELS*AWIDTH  store word address.
- St_Wdata  out  CHANNELS*DWIDTH  store data.
- Run_Cycles  out  32  start-to-done cycle count (see Configuration).

Function
REQ-007 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-008 SHALL, in IDLE, detect a 0->1 edge of Computation_Start and latch Cycle_Count as N; the FSM SHALL go to RUN if N>0 and directly to DONE if N==0.
REQ-009 SHALL ignore a Computation_Start that is already high when reset is released, until it has been seen low.
REQ-010 SHALL, in RUN, count k=0..N-1 with one cycle per k; in cycle k every channel SHALL drive Ld_En=1 and Ld_Addr=k.
REQ-011 SHALL register Ld_Rdata into Data_To_CGRA every cycle, so that the data for address k appears on Data_To_CGRA in cycle k+2 after the RUN entry edge.
REQ-012 SHALL hold Data_To_CGRA when Ld_En was low in the previous cycle.
REQ-013 SHALL move from RUN to DRAIN after cycle k=N-1; DRAIN SHALL last exactly DRAIN_CYCLES cycles, then the FSM SHALL go to DONE.
REQ-014 SHALL assert PE_Array_Busy exactly while the FSM is in RUN or DRAIN.
REQ-015 SHALL, in RUN or DRAIN, register Store_Valid[c]=1 at cycle t into St_En[c]=1, St_Wen[c]=all ones, St_Wdata[c]=Data_From_CGRA[c] and St_Addr[c]=store pointer p_c, all in cycle t+1, and then increment p_c.
REQ-016 SHALL keep the store pointers independent per channel, reset them to 0 on every new start, and let them wrap modulo 2^AWIDTH.
REQ-017 SHALL drive St_En=0 and St_Wen=0 in the next cycle when Store_Valid is high in IDLE or DONE, and SHALL NOT advance the pointer.
REQ-018 SHALL allow simultaneous store requests on all channels in one cycle, each completing independently.
REQ-019 SHALL hold Computation_Done=1 in DONE until Computation_Start is seen low, then return to IDLE with Computation_Done=0 in the following cycle.
REQ-020 SHALL ignore a deassertion of Computation_Start during RUN or DRAIN; completion is governed by REQ-019.

Reset
REQ-021 SHALL, with Rst high at a clock edge, put the FSM in IDLE, clear the counters, pointers, Computation_Done, PE_Array_Busy, Ld_En, St_En, St_Wen, Ld_Addr, St_Addr, St_Wdata, Data_To_CGRA and Run_Cycles to 0, and clear the start-edge register.
REQ-022 SHALL, on reset during RUN or DRAIN, abort the operation with no further store enables in the cycle after the reset edge.

Configuration
REQ-023 SHALL, when macro CGRA_CYCLE_STAT_EN is defined, clear Run_Cycles at start and increment it every cycle in RUN and DRAIN; the value SHALL be held from DONE until the next start.
REQ-024 SHALL, when CGRA_CYCLE_STAT_EN is undefined, tie Run_Cycles to 0 and implement no counter logic.

Verification
REQ-025 SHALL cover: CHANNELS=2, N=4, Ld_Rdata=addr*3 -> Ld_Addr 0,1,2,3 in consecutive cycles; Data_To_CGRA 0,3,6,9 from RUN-entry+2; PE_Array_Busy for 4+8 cycles; Run_Cycles=12 when the macro is defined.
REQ-026 SHALL cover: Store_Valid[0] on 3 cycles and Store_Valid[1] on 1 cycle with data 0xA,0xB,0xC / 0xD -> ch0 writes at addresses 0,1,2 and ch1 writes 0xD at address 0; St_Wen=4'hF.
REQ-027 SHALL cover: Cycle_Count=0 -> DONE one cycle after the start edge, with no Ld_En and Busy never high.
REQ-028 SHALL cover: Store_Valid pulsed in IDLE and DONE -> no St_En and pointers unchanged on the next run.
REQ-029 SHALL cover: Rst mid-RUN at k=2 of N=6 -> all outputs 0 next cycle; a fresh start edge restarts at address 0.
REQ-030 SHALL cover: Computation_Start held high through DONE for 5 cycles -> Done stays 1; Start drop -> Done 0 next cycle; no restart until the next rising edge.

Source files
------------

// File: rtl/cgra_stream_if_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cgra_stream_if_if                                         |
// | Bundle of control, load-port and store-port signals between the    |
// | CGRA stream controller (slave) and its environment (master).       |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
interface cgra_stream_if_if #(
    parameter int CHANNELS = 2,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 10,
    parameter int BYTE_LEN = DWIDTH / 8
);
    logic                         Computation_Start;
    logic [AWIDTH-1:0]            Cycle_Count;
    logic                         Computation_Done;
    logic                         PE_Array_Busy;
    logic [CHANNELS-1:0]          Ld_En;
    logic [CHANNELS*AWIDTH-1:0]   Ld_Addr;
    logic [CHANNELS*DWIDTH-1:0]   Ld_Rdata;
    logic [CHANNELS*DWIDTH-1:0]   Data_To_CGRA;
    logic [CHANNELS*DWIDTH-1:0]   Data_From_CGRA;
    logic [CHANNELS-1:0]          Store_Valid;
    logic [CHANNELS-1:0]          St_En;
    logic [CHANNELS*BYTE_LEN-1:0] St_Wen;
    logic [CHANNELS*AWIDTH-1:0]   St_Addr;
    logic [CHANNELS*DWIDTH-1:0]   St_Wdata;
    logic [31:0]                  Run_Cycles;

    modport slave (
        input  Computation_Start, Cycle_Count, Ld_Rdata, Data_From_CGRA, Store_Valid,
        output Computation_Done, PE_Array_Busy, Ld_En, Ld_Addr, Data_To_CGRA,
               St_En, St_Wen, St_Addr, St_Wdata, Run_Cycles
    );

    modport master (
        output Computation_Start, Cycle_Count, Ld_Rdata, Data_From_CGRA, Store_Valid,
        input  Computation_Done, PE_Array_Busy, Ld_En, Ld_Addr, Data_To_CGRA,
               St_En, St_Wen, St_Addr, St_Wdata, Run_Cycles
    );
endinterface
`default_nettype wire

// File: rtl/cgra_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cgra_stream_if                                            |
// | Streams N load words per channel into a CGRA PE array, then drains |
// | its stores into per-channel BRAM pointers.                         |
// | Option : define CGRA_CYCLE_STAT_EN to enable the Run_Cycles count. |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module cgra_stream_if #(
    parameter int CHANNELS     = 2,
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 10,
    parameter int DRAIN_CYCLES = 8,
    parameter int BYTE_LEN     = DWIDTH / 8
) (
    input  logic            Clk,
    input  logic            Rst,
    cgra_stream_if_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_drain_last = 8'(DRAIN_CYCLES - 1);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic                               r_start_low;
    logic                               w_start;
    logic                               w_busy;
    logic [AWIDTH-1:0]                  r_len;
    logic [AWIDTH-1:0]                  r_k;
    logic [7:0]                         r_drain;
    logic [CHANNELS-1:0]                r_ld_en_d;
    logic [CHANNELS-1:0]                r_st_en;
    logic [CHANNELS-1:0][BYTE_LEN-1:0]  r_st_wen;
    logic [CHANNELS-1:0][AWIDTH-1:0]    r_ptr;
    logic [CHANNELS-1:0][AWIDTH-1:0]    r_st_addr;
    logic [CHANNELS-1:0][DWIDTH-1:0]    r_dtc;
    logic [CHANNELS-1:0][DWIDTH-1:0]    r_st_wdata;

    // r_start_low is cleared by reset, so a start already high at release is not an edge
    assign w_start = (r_state == S_IDLE) && bus.Computation_Start && r_start_low;
    assign w_busy  = (r_state == S_RUN) || (r_state == S_DRAIN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = (bus.Cycle_Count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_k == r_len - AWIDTH'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain == c_drain_last) w_state_nxt = S_DONE;
            S_DONE:  if (!bus.Computation_Start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_start_low <= 1'b0;
            r_len       <= '0;
            r_k         <= '0;
            r_drain     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_low <= !bus.Computation_Start;
            if (w_start) r_len <= bus.Cycle_Count;
            r_k     <= (r_state == S_RUN && w_state_nxt == S_RUN) ? r_k + AWIDTH'(1) : '0;
            r_drain <= (r_state == S_DRAIN) ? r_drain + 8'd1 : '0;
        end
    end

    // Load data follows the BRAM by one cycle; Ld_En of the previous cycle qualifies Ld_Rdata
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ld_en_d  <= '0;
            r_dtc      <= '0;
            r_ptr      <= '0;
            r_st_en    <= '0;
            r_st_wen   <= '0;
            r_st_addr  <= '0;
            r_st_wdata <= '0;
        end else begin
            r_ld_en_d <= bus.Ld_En;
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_ld_en_d[c]) r_dtc[c] <= bus.Ld_Rdata[c*DWIDTH +: DWIDTH];
                r_st_en[c]  <= 1'b0;
                r_st_wen[c] <= '0;
                if (w_start) begin
                    r_ptr[c] <= '0;
                end else if (w_busy && bus.Store_Valid[c]) begin
                    r_st_en[c]    <= 1'b1;
                    r_st_wen[c]   <= '1;
                    r_st_addr[c]  <= r_ptr[c];
                    r_st_wdata[c] <= bus.Data_From_CGRA[c*DWIDTH +: DWIDTH];
                    r_ptr[c]      <= r_ptr[c] + AWIDTH'(1);
                end
            end
        end
    end

    assign bus.PE_Array_Busy    = w_busy;
    assign bus.Computation_Done = (r_state == S_DONE);
    assign bus.Ld_En            = {CHANNELS{r_state == S_RUN}};
    assign bus.Ld_Addr          = (r_state == S_RUN) ? {CHANNELS{r_k}} : '0;
    assign bus.Data_To_CGRA     = r_dtc;
    assign bus.St_En            = r_st_en;
    assign bus.St_Wen           = r_st_wen;
    assign bus.St_Addr          = r_st_addr;
    assign bus.St_Wdata         = r_st_wdata;

`ifdef CGRA_CYCLE_STAT_EN
    logic [31:0] r_run_cycles;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_run_cycles <= '0;
        end else if (w_start) begin
            r_run_cycles <= '0;
        end else if (w_busy) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign bus.Run_Cycles = r_run_cycles;
`else
    assign bus.Run_Cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cgra_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_cgra_stream_if                                         |
// | Randomized scoreboard bench for cgra_stream_if with a BRAM model.  |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_cgra_stream_if;
    localparam int CH = 2;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DR = 8;
    localparam int BL = DW / 8;

    typedef struct {
        int               cyc;
        logic [AW-1:0]    addr;
        logic [CH*DW-1:0] data;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ev_t              ld_q[$];
    ev_t              dat_q[$];
    ev_t              st_q[CH][$];
    bit               exp_busy[int];
    bit               exp_done[int];
    int               act_lo = 0;
    int               act_hi = 0;
    logic [AW-1:0]    m_ptr[CH];
    logic [31:0]      exp_rc = '0;
    logic [31:0]      salt = '0;
    logic [CH*DW-1:0] exp_dtc = '0;

    cgra_stream_if_if #(.CHANNELS(CH), .DWIDTH(DW), .AWIDTH(AW), .BYTE_LEN(BL)) bus ();

    cgra_stream_if #(
        .CHANNELS(CH), .DWIDTH(DW), .AWIDTH(AW), .DRAIN_CYCLES(DR), .BYTE_LEN(BL)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input int c, input logic [AW-1:0] a);
        logic [31:0] v;
        v = 32'(a) * 32'd3 + salt * 32'(c + 1);
        return DW'(v);
    endfunction

    // BRAM: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        for (int c = 0; c < CH; c++)
            bus.Ld_Rdata[c*DW +: DW] <= bus.Ld_En[c] ? word(c, bus.Ld_Addr[c*AW +: AW]) : DW'($urandom);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            if (bus.Ld_En != '0 || (ld_q.size() > 0 && ld_q[0].cyc == cyc)) begin
                if (ld_q.size() == 0) check("ld_en_unexpected", 256'(bus.Ld_En), 256'(0));
                else begin
                    e = ld_q.pop_front();
                    check("ld_cycle", 256'(cyc), 256'(e.cyc));
                    check("ld_en", 256'(bus.Ld_En), 256'({CH{1'b1}}));
                    for (int c = 0; c < CH; c++)
                        check("ld_addr", 256'(bus.Ld_Addr[c*AW +: AW]), 256'(e.addr));
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (bus.St_En[c] || (st_q[c].size() > 0 && st_q[c][0].cyc == cyc)) begin
                    if (st_q[c].size() == 0) check("st_en_unexpected", 256'(bus.St_En[c]), 256'(0));
                    else begin
                        e = st_q[c].pop_front();
                        check("st_cycle", 256'(cyc), 256'(e.cyc));
                        check("st_en", 256'(bus.St_En[c]), 256'(1));
                        check("st_wen", 256'(bus.St_Wen[c*BL +: BL]), 256'({BL{1'b1}}));
                        check("st_addr", 256'(bus.St_Addr[c*AW +: AW]), 256'(e.addr));
                        check("st_wdata", 256'(bus.St_Wdata[c*DW +: DW]), 256'(e.data[DW-1:0]));
                    end
                end else begin
                    check("st_wen_idle", 256'(bus.St_Wen[c*BL +: BL]), 256'(0));
                end
            end
            while (dat_q.size() > 0 && dat_q[0].cyc <= cyc) begin
                e = dat_q.pop_front();
                exp_dtc = e.data;
            end
            check("data_to_cgra", 256'(bus.Data_To_CGRA), 256'(exp_dtc));
            check("busy", 256'(bus.PE_Array_Busy), 256'(exp_busy.exists(cyc)));
            check("done", 256'(bus.Computation_Done), 256'(exp_done.exists(cyc)));
            if (exp_done.exists(cyc)) check("run_cycles", 256'(bus.Run_Cycles), 256'(exp_rc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH-1:0] rnd_sv(input int pct);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    function automatic logic [CH*DW-1:0] rnd_data();
        logic [CH*DW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // One cycle of store stimulus; a request in RUN/DRAIN lands one cycle later at the model pointer
    task automatic step(input logic [CH-1:0] sv, input logic [CH*DW-1:0] d);
        ev_t e;
        bus.Store_Valid    = sv;
        bus.Data_From_CGRA = d;
        if (cyc >= act_lo && cyc < act_hi) begin
            for (int c = 0; c < CH; c++) begin
                if (sv[c]) begin
                    e.cyc  = cyc + 1;
                    e.addr = m_ptr[c];
                    e.data = '0;
                    e.data[DW-1:0] = d[c*DW +: DW];
                    st_q[c].push_back(e);
                    m_ptr[c] = m_ptr[c] + AW'(1);
                end
            end
        end
        tick();
    endtask

    task automatic idle(input int n, input int pct);
        bus.Computation_Start = 1'b0;
        repeat (n) step(rnd_sv(pct), rnd_data());
    endtask

    // Expected run: loads k at c0+k, data at c0+k+2, busy for N+DR cycles
    task automatic arm(input int n_len, input int c0, input logic [31:0] s);
        ev_t e;
        salt = s;
        for (int k = 0; k < n_len; k++) begin
            e.cyc  = c0 + k;
            e.addr = AW'(k);
            e.data = '0;
            ld_q.push_back(e);
            e.cyc = c0 + k + 2;
            for (int c = 0; c < CH; c++) e.data[c*DW +: DW] = word(c, AW'(k));
            dat_q.push_back(e);
        end
        if (n_len > 0)
            for (int t = c0; t < c0 + n_len + DR; t++) exp_busy[t] = 1'b1;
        act_lo = c0;
        act_hi = (n_len > 0) ? c0 + n_len + DR : c0;
        for (int c = 0; c < CH; c++) m_ptr[c] = '0;
`ifdef CGRA_CYCLE_STAT_EN
        exp_rc = (n_len > 0) ? 32'(n_len + DR) : 32'd0;
`else
        exp_rc = 32'd0;
`endif
    endtask

    // mode 0: random stores, 1: directed A/B/C + D pattern, 2: stores every cycle
    task automatic start_run(input int n_len, input int hold, input int mode, input int pct, input bit wiggle);
        int n0, c0, dstart, cd, off;
        logic [CH-1:0] sv;
        logic [CH*DW-1:0] d;
        n0 = cyc;
        c0 = n0 + 1;
        arm(n_len, c0, (mode == 1) ? 32'd0 : 32'($urandom));
        dstart = (n_len == 0) ? c0 : c0 + n_len + DR;
        cd = dstart + hold;
        for (int t = dstart; t < cd; t++) exp_done[t] = 1'b1;
        bus.Cycle_Count = AW'(n_len);
        while (cyc < cd) begin
            if (cyc > n0) bus.Cycle_Count = AW'($urandom);
            if (cyc == cd - 1) bus.Computation_Start = 1'b0;
            else if (wiggle && cyc > n0 && cyc < dstart) bus.Computation_Start = 1'($urandom_range(0, 1));
            else bus.Computation_Start = 1'b1;
            sv = rnd_sv(pct);
            d  = rnd_data();
            if (mode == 1) begin
                sv  = '0;
                off = cyc - c0;
                if (off >= 0 && off < 3) begin
                    sv[0] = 1'b1;
                    d[0 +: DW] = DW'(32'hA + 32'(off));
                end
                if (off == 1) begin
                    sv[1] = 1'b1;
                    d[DW +: DW] = DW'(32'hD);
                end
            end else if (mode == 2) begin
                sv = '1;
            end
            step(sv, d);
        end
    endtask

    task automatic reset_run(input int n_len, input int kab);
        int c0, rc;
        c0 = cyc + 1;
        arm(n_len, c0, 32'($urandom));
        bus.Cycle_Count = AW'(n_len);
        bus.Computation_Start = 1'b1;
        while (cyc < c0 + kab) step(rnd_sv(60), rnd_data());
        rst = 1'b1;
        rc = cyc + 1;
        step(rnd_sv(60), rnd_data());
        while (ld_q.size() > 0 && ld_q[$].cyc >= rc) void'(ld_q.pop_back());
        while (dat_q.size() > 0 && dat_q[$].cyc >= rc) void'(dat_q.pop_back());
        for (int c = 0; c < CH; c++)
            while (st_q[c].size() > 0 && st_q[c][$].cyc >= rc) void'(st_q[c].pop_back());
        begin
            ev_t z;
            z.cyc = rc; z.addr = '0; z.data = '0;
            dat_q.push_back(z);
        end
        for (int t = rc; t < c0 + n_len + DR; t++) exp_busy.delete(t);
        act_hi = rc;
        check("rst_ld_addr", 256'(bus.Ld_Addr), 256'(0));
        check("rst_st_addr", 256'(bus.St_Addr), 256'(0));
        check("rst_st_wdata", 256'(bus.St_Wdata), 256'(0));
        check("rst_st_wen", 256'(bus.St_Wen), 256'(0));
        check("rst_run_cycles", 256'(bus.Run_Cycles), 256'(0));
        rst = 1'b0;
        // start still high after reset: must not restart
        repeat (4) step(rnd_sv(30), rnd_data());
        idle(2, 30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.Computation_Start = 1'b1;
        bus.Cycle_Count       = AW'(5);
        bus.Store_Valid       = '0;
        bus.Data_From_CGRA    = '0;
        tick();
        mon_on = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) step(rnd_sv(50), rnd_data());
        idle(2, 50);

        start_run(4, 3, 1, 0, 1'b0);
        idle(3, 50);
        start_run(0, 2, 0, 50, 1'b0);
        idle(2, 50);
        start_run(3, 5, 0, 80, 1'b0);
        idle(3, 80);
        reset_run(6, 2);
        start_run(5, 2, 0, 50, 1'b0);
        idle(2, 50);
        for (int r = 0; r < 15; r++) begin
            start_run(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20)),
                      int'($urandom_range(1, 6)), 0, int'($urandom_range(0, 100)),
                      1'($urandom_range(0, 1)));
            idle(int'($urandom_range(1, 4)), int'($urandom_range(0, 100)));
        end
        start_run(1023, 1, 2, 0, 1'b0);
        idle(4, 50);

        check("ld_q_drained", 256'(ld_q.size()), 256'(0));
        for (int c = 0; c < CH; c++) check("st_q_drained", 256'(st_q[c].size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
